// File: rtl/dlx_pipe_pkg.sv
// Shared types and helpers for the DLX hazard/forwarding scoreboard.
// Entries carry rd at a fixed width so the struct stays parameter-independent.
package dlx_pipe_pkg;

    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    function automatic int unsigned fwd_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dlx_fwd_match.sv
// Youngest-match search of one source register against all tracked stages,
// plus a readiness flag for load results that are not yet forwardable.
module dlx_fwd_match
    import dlx_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned FWD_W    = fwd_width(DEPTH)
) (
    input  sb_entry_t [DEPTH:1] entries,
    input  logic [REG_AW-1:0]   src_sel,
    input  logic                src_used,
    output logic [FWD_W-1:0]    match_stage,
    output logic                match_ready
);

    logic [SB_RD_W-1:0] src_ext;

    assign src_ext = SB_RD_W'(src_sel);

    // Scan oldest to youngest so the youngest hit is the last one written.
    always_comb begin
        match_stage = FWD_W'(FWD_RF);
        match_ready = 1'b1;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (entries[k].valid && entries[k].regwrite && src_used &&
                (entries[k].rd == src_ext) && (entries[k].rd != '0)) begin
                match_stage = FWD_W'(k);
                match_ready = ~entries[k].is_load || (k >= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/dlx_hazard_scoreboard.sv
// DLX hazard controller: tracks in-flight destinations EX..WB, produces ID/EX
// forwarding selects, the load-use stall and a saturating stall counter.
module dlx_hazard_scoreboard
    import dlx_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned STALL_CW = 16,
    localparam int unsigned FWD_W   = fwd_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1_sel,
    input  logic [REG_AW-1:0]   id_rs2_sel,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic                id_regwrite,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output logic [FWD_W-1:0]    id_fwd_rs1,
    output logic [FWD_W-1:0]    id_fwd_rs2,
    output logic [FWD_W-1:0]    ex_fwd_rs1,
    output logic [FWD_W-1:0]    ex_fwd_rs2,
    output logic [DEPTH-1:0]    stage_valid,
    output logic [STALL_CW-1:0] stall_count
);

    sb_entry_t [DEPTH:1] sb_q, sb_d;
    logic [FWD_W-1:0]    ex_fwd_rs1_q, ex_fwd_rs1_d;
    logic [FWD_W-1:0]    ex_fwd_rs2_q, ex_fwd_rs2_d;
    logic [STALL_CW-1:0] stall_count_q, stall_count_d;
    logic                rs1_ready, rs2_ready;
    logic                enter_ex;

    dlx_fwd_match #(
        .REG_AW  (REG_AW),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .FWD_W   (FWD_W)
    ) u_match_rs1 (
        .entries    (sb_q),
        .src_sel    (id_rs1_sel),
        .src_used   (id_rs1_used),
        .match_stage(id_fwd_rs1),
        .match_ready(rs1_ready)
    );

    dlx_fwd_match #(
        .REG_AW  (REG_AW),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .FWD_W   (FWD_W)
    ) u_match_rs2 (
        .entries    (sb_q),
        .src_sel    (id_rs2_sel),
        .src_used   (id_rs2_used),
        .match_stage(id_fwd_rs2),
        .match_ready(rs2_ready)
    );

    assign stall    = id_valid & ~flush & (~rs1_ready | ~rs2_ready);
    assign enter_ex = id_valid & ~flush & ~stall;

    // A producer one stage past DEPTH has already written the register file.
    function automatic logic [FWD_W-1:0] ex_sel(input logic [FWD_W-1:0] id_sel);
        if ((id_sel == FWD_W'(FWD_RF)) || (id_sel == FWD_W'(DEPTH)))
            return FWD_W'(FWD_RF);
        return id_sel + FWD_W'(1);
    endfunction

    always_comb begin
        sb_d = '0;
        if (enter_ex) begin
            sb_d[1].valid    = 1'b1;
            sb_d[1].regwrite = id_regwrite;
            sb_d[1].rd       = SB_RD_W'(id_rd);
            sb_d[1].is_load  = id_is_load;
        end
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_comb begin
        ex_fwd_rs1_d = '0;
        ex_fwd_rs2_d = '0;
        if (enter_ex) begin
            ex_fwd_rs1_d = ex_sel(id_fwd_rs1);
            ex_fwd_rs2_d = ex_sel(id_fwd_rs2);
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + STALL_CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q          <= '0;
            ex_fwd_rs1_q  <= '0;
            ex_fwd_rs2_q  <= '0;
            stall_count_q <= '0;
        end else begin
            sb_q          <= sb_d;
            ex_fwd_rs1_q  <= ex_fwd_rs1_d;
            ex_fwd_rs2_q  <= ex_fwd_rs2_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            stage_valid[k-1] = sb_q[k].valid;
        end
    end

    assign ex_fwd_rs1  = ex_fwd_rs1_q;
    assign ex_fwd_rs2  = ex_fwd_rs2_q;
    assign stall_count = stall_count_q;

endmodule
